// File: rtl/regfile_wr_arbiter.sv
// Register file write-port owner: zero-clears every entry after reset, then
// round-robin arbitrates the ALU (port 0) and LSU (port 1) writebacks onto one registered port.
module regfile_wr_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_wen,
    output logic                  init_done
);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    last_grant_q, last_grant_d;
    logic                    rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
    logic                    init_done_q, init_done_d;

    logic                    grant0, grant1;
    logic                    hs0, hs1;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_data;

    // Ready depends only on state, valids and last_grant; never on rf_* outputs.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state_q == ST_RUN) && grant0;
    assign req1_ready = (state_q == ST_RUN) && grant1;
    assign hs0        = req0_valid && req0_ready;
    assign hs1        = req1_valid && req1_ready;
    assign acc_addr   = hs1 ? req1_addr : req0_addr;
    assign acc_data   = hs1 ? req1_data : req0_data;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        init_done_d  = init_done_q;
        unique case (state_q)
            ST_CLEAR: begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = clr_cnt_q;
                rf_wdata_d = '0;
                clr_cnt_d  = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == '1) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                // A write to x0 still completes the handshake; only the issue is suppressed.
                if (hs0 || hs1) begin
                    last_grant_d = hs1;
                    rf_waddr_d   = acc_addr;
                    rf_wdata_d   = acc_data;
                    rf_wen_d     = !((ZERO_REG != 0) && (acc_addr == '0));
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            init_done_q  <= init_done_d;
        end
    end

    assign rf_wen    = rf_wen_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: two instances (ZERO_REG=1 and 0) on shared stimulus,
// checked against a counting/queue-free reference model of the clear and arbitration rules.
module tb_regfile_wr_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;

    // index 0: ZERO_REG=1, index 1: ZERO_REG=0
    logic          rdy0 [2];
    logic          rdy1 [2];
    logic          wen  [2];
    logic [AW-1:0] waddr[2];
    logic [DW-1:0] wdata[2];
    logic          done [2];

    regfile_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rdy0[0]),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rdy1[0]),
        .rf_waddr(waddr[0]), .rf_wdata(wdata[0]), .rf_wen(wen[0]), .init_done(done[0])
    );

    regfile_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG(0)) dut_n (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rdy0[1]),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rdy1[1]),
        .rf_waddr(waddr[1]), .rf_wdata(wdata[1]), .rf_wen(wen[1]), .init_done(done[1])
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Reference model: number of clear writes done, last granted port, expected rf_* per instance.
    int            m_clr;
    bit            m_last;
    bit            m_wen [2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_data[2];
    bit            m_chk [2];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        assert (act === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int exp_grant();
        if (m_clr < DEPTH) return -1;
        if (req0_valid && req1_valid) return m_last ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic set_req(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    task automatic model_reset();
        m_clr  = 0;
        m_last = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_wen[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0; m_chk[k] = 1'b1;
        end
    endtask

    // Asserts reset between edges, checks the asynchronous effect, holds across one edge.
    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_wen[%0d]", k),   wen[k],   0);
            chk($sformatf("rst_waddr[%0d]", k), waddr[k], 0);
            chk($sformatf("rst_wdata[%0d]", k), wdata[k], 0);
            chk($sformatf("rst_done[%0d]", k),  done[k],  0);
            chk($sformatf("rst_rdy0[%0d]", k),  rdy0[k],  0);
            chk($sformatf("rst_rdy1[%0d]", k),  rdy1[k],  0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_hold_wen[%0d]", k),  wen[k],  0);
            chk($sformatf("rst_hold_done[%0d]", k), done[k], 0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: check readys before the edge, advance the model, check rf_* after it.
    task automatic cycle(output int g);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        #2;
        g = exp_grant();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready0[%0d]", k), rdy0[k], (g == 0));
            chk($sformatf("ready1[%0d]", k), rdy1[k], (g == 1));
        end
        @(posedge clk);
        if (m_clr < DEPTH) begin
            for (int k = 0; k < 2; k++) begin
                m_wen[k] = 1'b1; m_addr[k] = AW'(m_clr); m_data[k] = '0; m_chk[k] = 1'b1;
            end
            m_clr++;
        end else if (g >= 0) begin
            a = (g == 1) ? req1_addr : req0_addr;
            d = (g == 1) ? req1_data : req0_data;
            m_last = (g == 1);
            for (int k = 0; k < 2; k++) begin
                m_wen[k]  = !(k == 0 && a == '0);
                m_chk[k]  = m_wen[k];
                m_addr[k] = a;
                m_data[k] = d;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_wen[k] = 1'b0; m_chk[k] = 1'b1;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rf_wen[%0d]", k), wen[k], m_wen[k]);
            if (m_chk[k]) begin
                chk($sformatf("rf_waddr[%0d]", k), waddr[k], m_addr[k]);
                chk($sformatf("rf_wdata[%0d]", k), wdata[k], m_data[k]);
            end
            chk($sformatf("init_done[%0d]", k), done[k], (m_clr == DEPTH));
        end
    endtask

    initial begin
        int g;
        int prev_g;
        int first_acc;
        logic          v0, v1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;

        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        #1;

        // Clear sequence with req0 pending throughout: accepted in first RUN cycle.
        set_req(1'b1, 5'd5, 32'h55, 1'b0, '0, '0);
        apply_reset();
        first_acc = -1;
        for (int i = 0; i < 40; i++) begin
            cycle(g);
            if (g == 0 && first_acc < 0) begin
                first_acc = i;
                req0_valid = 1'b0;
            end
        end
        chk("first_accept_cycle", first_acc, DEPTH);

        // Both valid every cycle: grants must alternate.
        set_req(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
        prev_g = -1;
        for (int i = 0; i < 6; i++) begin
            cycle(g);
            if (i > 0) chk("alternate", (g != prev_g) && (g >= 0), 1);
            prev_g = g;
        end
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        cycle(g);

        // req1 alone three times, then both: port 0 must win.
        set_req(1'b0, '0, '0, 1'b1, 5'd7, 32'h77);
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            chk("req1_only_grant", g, 1);
        end
        set_req(1'b1, 5'd8, 32'h88, 1'b1, 5'd7, 32'h77);
        cycle(g);
        chk("both_after_req1", g, 0);
        cycle(g);
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        cycle(g);

        // Write to address 0: suppressed in the ZERO_REG=1 instance only.
        set_req(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
        cycle(g);
        chk("x0_accept", g, 0);
        chk("x0_wen_zr1", wen[0], 0);
        chk("x0_wen_zr0", wen[1], 1);
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        cycle(g);

        // Randomized traffic; unaccepted requests hold stable.
        v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int i = 0; i < 400; i++) begin
            set_req(v0, a0, d0, v1, a1, d1);
            cycle(g);
            if (!v0 || g == 0) begin
                v0 = 1'($urandom_range(0, 1));
                a0 = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
                d0 = $urandom;
            end
            if (!v1 || g == 1) begin
                v1 = 1'($urandom_range(0, 1));
                a1 = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
                d1 = $urandom;
            end
        end

        // Reset in mid-clear (after addr 10 issued) restarts the clear from 0.
        set_req(1'b0, '0, '0, 1'b0, '0, '0);
        apply_reset();
        for (int i = 0; i < 11; i++) cycle(g);
        chk("midclear_addr", waddr[0], 10);
        apply_reset();
        cycle(g);
        chk("restart_addr", waddr[0], 0);
        for (int i = 0; i < 34; i++) cycle(g);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
